// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic                 found_o,
   output logic [$clog2(N)-1:0] pick_id_o,
   output logic [N-1:0]         pick_o
);

   localparam int unsigned IdW = $clog2(N);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] masked;

   // Upper copy covers the wrap, so a single ascending scan yields the rr order.
   always_comb begin
      dbl    = {req_i, req_i};
      masked = '0;
      for (int unsigned i = 0; i < 2 * N; i++) begin
         masked[i] = dbl[i] && (i >= 32'(ptr_i));
      end
      found_o   = 1'b0;
      pick_id_o = '0;
      pick_o    = '0;
      for (int unsigned i = 0; i < 2 * N; i++) begin
         if (masked[i] && !found_o) begin
            found_o   = 1'b1;
            pick_id_o = (i >= N) ? IdW'(i - N) : IdW'(i);
         end
      end
      if (found_o) begin
         pick_o[pick_id_o] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant, idle gap between grants
// and an optional grant-hold limit that revokes with a one-cycle timeout pulse.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N-1:0]         req_i,
   output logic [N-1:0]         gnt_o,
   output logic                 busy_o,
   output logic [$clog2(N)-1:0] owner_id_o,
   output logic                 timeout_o
);

   localparam int unsigned IdW   = $clog2(N);
   localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   arb_state_t       state_q;
   logic [IdW-1:0]   ptr_q;
   logic [IdW-1:0]   owner_q;
   logic [HoldW-1:0] hold_q;
   logic [N-1:0]     gnt_q;
   logic             busy_q;
   logic             timeout_q;

   logic             found;
   logic [IdW-1:0]   pick_id;
   logic [N-1:0]     pick;
   logic             owner_req;
   logic             limit_hit;

   rr_pick #(
      .N (N)
   ) u_pick (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .found_o   (found),
      .pick_id_o (pick_id),
      .pick_o    (pick)
   );

   assign owner_req = req_i[owner_q];
   assign limit_hit = (MAX_HOLD != 0) && (hold_q == HoldLast);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, GAP: begin
               timeout_q <= 1'b0;
               if (found) begin
                  gnt_q   <= pick;
                  busy_q  <= 1'b1;
                  owner_q <= pick_id;
                  hold_q  <= '0;
                  state_q <= GRANT;
               end else begin
                  state_q <= IDLE;
               end
            end
            GRANT: begin
               if (!owner_req || limit_hit) begin
                  gnt_q     <= '0;
                  busy_q    <= 1'b0;
                  owner_q   <= '0;
                  ptr_q     <= IdW'(rr_next(32'(owner_q), N));
                  // Release takes priority: a pulse only when the owner still wants it.
                  timeout_q <= owner_req;
                  state_q   <= GAP;
               end else if (hold_q != HoldLast) begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign busy_o     = busy_q;
   assign owner_id_o = owner_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed scoreboard bench for rr_arbiter: N=4/M=8, N=4/M=0 and N=3/M=2 instances.
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, req0;
   logic [2:0] req3;

   logic [3:0] gnt, gnt0;
   logic [2:0] gnt3;
   logic       busy, busy0, busy3;
   logic [1:0] owner, owner0, owner3;
   logic       to, to0, to3;

   typedef struct {
      int         sel;
      string      tag;
      logic [3:0] gnt;
      logic       to;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
      .clk_i (clk), .rst_ni (rst_n), .req_i (req),
      .gnt_o (gnt), .busy_o (busy), .owner_id_o (owner), .timeout_o (to)
   );

   rr_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
      .clk_i (clk), .rst_ni (rst_n), .req_i (req0),
      .gnt_o (gnt0), .busy_o (busy0), .owner_id_o (owner0), .timeout_o (to0)
   );

   rr_arbiter #(.N(3), .MAX_HOLD(2)) dut3 (
      .clk_i (clk), .rst_ni (rst_n), .req_i (req3),
      .gnt_o (gnt3), .busy_o (busy3), .owner_id_o (owner3), .timeout_o (to3)
   );

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) begin
         if (g[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   task automatic push(input int sel, input string tag, input logic [3:0] g, input logic t);
      exp_t e;
      e.sel = sel;
      e.tag = tag;
      e.gnt = g;
      e.to  = t;
      sb.push_back(e);
   endtask

   task automatic chk();
      exp_t       e;
      logic [7:0] obs, want;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL sb_underflow observed=none required=entry");
         return;
      end
      e = sb.pop_front();
      case (e.sel)
         0:       obs = {gnt, busy, owner, to};
         1:       obs = {gnt0, busy0, owner0, to0};
         default: obs = {1'b0, gnt3, busy3, owner3, to3};
      endcase
      want = {e.gnt, |e.gnt, idx_of(e.gnt), e.to};
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed{gnt,busy,id,to}=%b required=%b", e.tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int sel, input string tag, input logic [3:0] g, input logic t);
      push(sel, tag, g, t);
      tick();
      chk();
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] g;
      rst_n = 1'b0;
      req   = '0;
      req0  = '0;
      req3  = '0;

      // Reset values and asynchronous mid-grant reset
      #2;
      push(0, "rst_state", 4'b0000, 1'b0); chk();
      push(1, "rst_state0", 4'b0000, 1'b0); chk();
      push(2, "rst_state3", 4'b0000, 1'b0); chk();
      #10 rst_n = 1'b1;
      req = 4'b0001;
      step(0, "t1_grant", 4'b0001, 1'b0);
      step(0, "t1_hold", 4'b0001, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      push(0, "t1_async_rst", 4'b0000, 1'b0); chk();
      req = 4'b0010;
      #2 rst_n = 1'b1;
      step(0, "t1_post_rst", 4'b0010, 1'b0);
      req = 4'b0000;
      step(0, "t1_release", 4'b0000, 1'b0);

      // Round-robin with all four requesting
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << (k % 4);
         step(0, "t2_grant", g, 1'b0);
         req = 4'b1111 & ~g;
         step(0, "t2_gap", 4'b0000, 1'b0);
         req = 4'b1111;
      end
      req = 4'b0000;
      step(0, "t2_idle", 4'b0000, 1'b0);

      // Hold limit with a single persistent requester
      do_reset();
      req = 4'b0100;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 8; c++) step(0, "t3_hold", 4'b0100, 1'b0);
         step(0, "t3_timeout", 4'b0000, 1'b1);
      end
      step(0, "t3_regrant", 4'b0100, 1'b0);
      req = 4'b0000;
      step(0, "t3_release", 4'b0000, 1'b0);
      step(0, "t3_idle", 4'b0000, 1'b0);

      // Release coinciding with the limit edge
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 8; c++) step(0, "t6_hold", 4'b0001, 1'b0);
      req = 4'b0000;
      step(0, "t6_coincide", 4'b0000, 1'b0);
      step(0, "t6_idle", 4'b0000, 1'b0);

      // Two-master protocol
      do_reset();
      req = 4'b0011;
      step(0, "t4_m0", 4'b0001, 1'b0);
      req = 4'b0010;
      step(0, "t4_gap1", 4'b0000, 1'b0);
      step(0, "t4_m1", 4'b0010, 1'b0);
      req = 4'b0001;
      step(0, "t4_gap2", 4'b0000, 1'b0);
      req = 4'b0011;
      step(0, "t4_m0_again", 4'b0001, 1'b0);
      req = 4'b0010;
      step(0, "t4_gap3", 4'b0000, 1'b0);
      step(0, "t4_m1_again", 4'b0010, 1'b0);
      req = 4'b0000;
      step(0, "t4_release", 4'b0000, 1'b0);

      // Limit disabled
      do_reset();
      req0 = 4'b0001;
      for (int c = 0; c < 100; c++) step(1, "t5_nolimit", 4'b0001, 1'b0);
      req0 = 4'b0000;
      step(1, "t5_release", 4'b0000, 1'b0);

      // N=3 pointer wrap with MAX_HOLD=2
      do_reset();
      req3 = 3'b111;
      for (int k = 0; k < 4; k++) begin
         g = 4'b0001 << (k % 3);
         step(2, "n3_grant", g, 1'b0);
         step(2, "n3_grant", g, 1'b0);
         step(2, "n3_timeout", 4'b0000, 1'b1);
      end
      req3 = 3'b000;
      step(2, "n3_idle", 4'b0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
